// File: rtl/issue_queue_if.sv
// Signal bundle between dispatch, the issue queue and the execute stage.
// master = dispatch/execute side, slave = the issue queue.
interface issue_queue_if #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned TAG_W     = 6,
  parameter int unsigned PAYLOAD_W = 128
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic                 flush;
  logic                 disp_valid;
  logic                 disp_ready;
  logic [31:0]          disp_instr_num;
  logic [TAG_W-1:0]     disp_srcA_map;
  logic [TAG_W-1:0]     disp_srcB_map;
  logic                 disp_srcA_rdy;
  logic                 disp_srcB_rdy;
  logic [TAG_W-1:0]     disp_RegWr_map;
  logic                 disp_RegWr_flag;
  logic [PAYLOAD_W-1:0] disp_payload;
  logic                 broadcast_flag;
  logic [TAG_W-1:0]     broadcast_map;
  logic                 issue_valid;
  logic [31:0]          issue_instr_num;
  logic [TAG_W-1:0]     issue_RegWr_map;
  logic                 issue_RegWr_flag;
  logic [PAYLOAD_W-1:0] issue_payload;
  logic [CNT_W-1:0]     occupancy;

  modport master (
    output flush, disp_valid, disp_instr_num, disp_srcA_map, disp_srcB_map,
           disp_srcA_rdy, disp_srcB_rdy, disp_RegWr_map, disp_RegWr_flag,
           disp_payload, broadcast_flag, broadcast_map,
    input  disp_ready, issue_valid, issue_instr_num, issue_RegWr_map,
           issue_RegWr_flag, issue_payload, occupancy
  );

  modport slave (
    input  flush, disp_valid, disp_instr_num, disp_srcA_map, disp_srcB_map,
           disp_srcA_rdy, disp_srcB_rdy, disp_RegWr_map, disp_RegWr_flag,
           disp_payload, broadcast_flag, broadcast_map,
    output disp_ready, issue_valid, issue_instr_num, issue_RegWr_map,
           issue_RegWr_flag, issue_payload, occupancy
  );
endinterface

// File: rtl/issue_queue.sv
// Out-of-order issue queue: holds renamed instructions until both sources are
// ready and issues the oldest ready one per cycle into the execute stage.
module issue_queue #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned TAG_W     = 6,
  parameter int unsigned PAYLOAD_W = 128
) (
  input logic         CLK,
  input logic         RESET,
  issue_queue_if.slave iq
);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;

  logic [DEPTH-1:0]     valid;
  logic [DEPTH-1:0]     rdy_a;
  logic [DEPTH-1:0]     rdy_b;
  logic [DEPTH-1:0]     wr_flag;
  logic [31:0]          num     [DEPTH];
  logic [TAG_W-1:0]     src_a   [DEPTH];
  logic [TAG_W-1:0]     src_b   [DEPTH];
  logic [TAG_W-1:0]     wr_map  [DEPTH];
  logic [PAYLOAD_W-1:0] payload [DEPTH];
  logic [CNT_W-1:0]     occ;

  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_found;
  logic [31:0]      sel_num;
  logic             disp_fire;

  assign iq.disp_ready = (occ != CNT_W'(DEPTH)) && !iq.flush;
  assign disp_fire     = iq.disp_valid && iq.disp_ready;
  assign iq.occupancy  = occ;

  // Lowest-index free slot
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid[i]) free_idx = IDX_W'(i);
    end
  end

  // Oldest ready entry wins; instr_num values are unique so no tie-break needed
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    sel_num   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && rdy_a[i] && rdy_b[i] && (!sel_found || num[i] < sel_num)) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_num   = num[i];
      end
    end
  end

  // Control state: valid bits, occupancy and the issue register stage
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      valid               <= '0;
      occ                 <= '0;
      iq.issue_valid      <= 1'b0;
      iq.issue_instr_num  <= '0;
      iq.issue_RegWr_map  <= '0;
      iq.issue_RegWr_flag <= 1'b0;
      iq.issue_payload    <= '0;
    end else if (iq.flush) begin
      valid               <= '0;
      occ                 <= '0;
      iq.issue_valid      <= 1'b0;
      iq.issue_instr_num  <= '0;
      iq.issue_RegWr_map  <= '0;
      iq.issue_RegWr_flag <= 1'b0;
      iq.issue_payload    <= '0;
    end else begin
      if (sel_found) begin
        iq.issue_valid      <= 1'b1;
        iq.issue_instr_num  <= num[sel_idx];
        iq.issue_RegWr_map  <= wr_map[sel_idx];
        iq.issue_RegWr_flag <= wr_flag[sel_idx];
        iq.issue_payload    <= payload[sel_idx];
        valid[sel_idx]      <= 1'b0;
      end else begin
        iq.issue_valid      <= 1'b0;
        iq.issue_instr_num  <= '0;
        iq.issue_RegWr_map  <= '0;
        iq.issue_RegWr_flag <= 1'b0;
        iq.issue_payload    <= '0;
      end
      // free_idx is never the winner, so this cannot collide with the clear above
      if (disp_fire) valid[free_idx] <= 1'b1;
      occ <= occ + CNT_W'(disp_fire) - CNT_W'(sel_found);
    end
  end

  // Entry contents and wakeup; meaningful only while the matching valid bit is set
  always_ff @(posedge CLK) begin
    if (iq.broadcast_flag) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (src_a[i] == iq.broadcast_map) rdy_a[i] <= 1'b1;
        if (src_b[i] == iq.broadcast_map) rdy_b[i] <= 1'b1;
      end
    end
    if (disp_fire) begin
      num[free_idx]     <= iq.disp_instr_num;
      src_a[free_idx]   <= iq.disp_srcA_map;
      src_b[free_idx]   <= iq.disp_srcB_map;
      wr_map[free_idx]  <= iq.disp_RegWr_map;
      wr_flag[free_idx] <= iq.disp_RegWr_flag;
      payload[free_idx] <= iq.disp_payload;
      rdy_a[free_idx]   <= iq.disp_srcA_rdy ||
                           (iq.broadcast_flag && iq.disp_srcA_map == iq.broadcast_map);
      rdy_b[free_idx]   <= iq.disp_srcB_rdy ||
                           (iq.broadcast_flag && iq.disp_srcB_map == iq.broadcast_map);
    end
  end
endmodule

// File: tb/tb_issue_queue.sv
// Scoreboard bench for issue_queue: a list-based reference model predicts each
// issue, and an independent monitor compares whatever the DUT presents.
module tb_issue_queue;
  localparam int unsigned DEPTH     = 8;
  localparam int unsigned TAG_W     = 6;
  localparam int unsigned PAYLOAD_W = 128;

  typedef struct {
    logic [31:0]          num;
    logic [TAG_W-1:0]     a;
    logic [TAG_W-1:0]     b;
    bit                   ra;
    bit                   rb;
    logic [TAG_W-1:0]     wm;
    bit                   wf;
    logic [PAYLOAD_W-1:0] pl;
  } ent_t;

  logic CLK;
  logic RESET;
  issue_queue_if #(.DEPTH(DEPTH), .TAG_W(TAG_W), .PAYLOAD_W(PAYLOAD_W)) iq ();

  issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .PAYLOAD_W(PAYLOAD_W)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .iq    (iq.slave)
  );

  int   checks   = 0;
  int   failures = 0;
  ent_t model[$];
  ent_t sb[$];
  logic [31:0] next_num = 32'd1;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: compare every issue cycle against the scoreboard head
  always @(posedge CLK) begin
    ent_t x;
    #1;
    if (!RESET) begin
      if (iq.issue_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_issue", iq.issue_instr_num, 0);
        end else begin
          x = sb.pop_front();
          chk("issue_num", iq.issue_instr_num, x.num);
          chk("issue_wmap", iq.issue_RegWr_map, x.wm);
          chk("issue_wflag", iq.issue_RegWr_flag, x.wf);
          chk("issue_payload", iq.issue_payload, x.pl);
        end
      end else begin
        chk("missing_issue", sb.size(), 0);
        chk("bubble_fields", {iq.issue_instr_num, iq.issue_RegWr_flag, iq.issue_payload[63:0]}, 0);
      end
    end
  end

  task automatic idle_inputs();
    iq.flush = 0; iq.disp_valid = 0; iq.disp_instr_num = 0;
    iq.disp_srcA_map = 0; iq.disp_srcB_map = 0; iq.disp_srcA_rdy = 0; iq.disp_srcB_rdy = 0;
    iq.disp_RegWr_map = 0; iq.disp_RegWr_flag = 0; iq.disp_payload = 0;
    iq.broadcast_flag = 0; iq.broadcast_map = 0;
  endtask

  // One cycle: drive inputs, then advance the reference model across the coming edge
  task automatic step(input bit dv, input logic [TAG_W-1:0] na, input bit ra,
                      input logic [TAG_W-1:0] nb, input bit rb,
                      input bit bf, input logic [TAG_W-1:0] bm, input bit fl);
    ent_t e;
    int   w;
    bit   er;
    @(negedge CLK);
    chk("occupancy", iq.occupancy, model.size());
    e.num = next_num; e.a = na; e.b = nb;
    e.wm = TAG_W'($urandom); e.wf = 1'($urandom);
    e.pl = {$urandom, $urandom, $urandom, $urandom};
    iq.flush = fl; iq.disp_valid = dv; iq.disp_instr_num = e.num;
    iq.disp_srcA_map = na; iq.disp_srcB_map = nb; iq.disp_srcA_rdy = ra; iq.disp_srcB_rdy = rb;
    iq.disp_RegWr_map = e.wm; iq.disp_RegWr_flag = e.wf; iq.disp_payload = e.pl;
    iq.broadcast_flag = bf; iq.broadcast_map = bm;
    #1;
    er = (model.size() < DEPTH) && !fl;
    chk("disp_ready", iq.disp_ready, er);
    if (fl) begin
      model.delete();
    end else begin
      w = -1;
      foreach (model[i])
        if (model[i].ra && model[i].rb && (w < 0 || model[i].num < model[w].num)) w = i;
      if (bf) begin
        foreach (model[i]) begin
          if (model[i].a == bm) model[i].ra = 1;
          if (model[i].b == bm) model[i].rb = 1;
        end
      end
      if (w >= 0) begin
        sb.push_back(model[w]);
        model.delete(w);
      end
      if (dv && er) begin
        e.ra = ra || (bf && na == bm);
        e.rb = rb || (bf && nb == bm);
        model.push_back(e);
      end
    end
    if (dv) next_num++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Reset asserted and released between clock edges
  task automatic async_reset();
    idle_inputs();
    #1 RESET = 1;
    #1;
    chk("rst_issue_valid", iq.issue_valid, 0);
    chk("rst_issue_num", iq.issue_instr_num, 0);
    chk("rst_issue_wmap", iq.issue_RegWr_map, 0);
    chk("rst_issue_wflag", iq.issue_RegWr_flag, 0);
    chk("rst_issue_payload", iq.issue_payload, 0);
    chk("rst_occupancy", iq.occupancy, 0);
    model.delete();
    sb.delete();
    #1 RESET = 0;
    #1;
    chk("rst_disp_ready", iq.disp_ready, 1);
  endtask

  initial begin
    RESET = 1;
    idle_inputs();
    @(negedge CLK);
    @(negedge CLK);
    RESET = 0;
    #1;
    chk("init_occupancy", iq.occupancy, 0);
    chk("init_issue_valid", iq.issue_valid, 0);
    chk("init_disp_ready", iq.disp_ready, 1);

    // Ready instruction issues one cycle after dispatch
    step(1, 1, 1, 2, 1, 0, 0, 0);
    idle(2);

    // Younger ready instruction overtakes an older waiting one
    step(1, 12, 0, 1, 1, 0, 0, 0);
    step(1, 2, 1, 3, 1, 0, 0, 0);
    idle(1);
    step(0, 0, 0, 0, 0, 1, 12, 0);
    idle(2);

    // Fill all entries waiting on tag 3, then drain oldest-first
    for (int i = 0; i < DEPTH; i++) step(1, 3, 0, 3, 0, 0, 0, 0);
    @(negedge CLK);
    chk("full_occupancy", iq.occupancy, DEPTH);
    chk("full_ready", iq.disp_ready, 0);
    step(1, 0, 1, 0, 1, 1, 3, 0);
    idle(DEPTH + 2);

    // Dispatch-time wakeup bypass on source B
    step(1, 0, 1, 9, 0, 1, 9, 0);
    idle(2);

    // Flush with a dispatch in the same cycle drops everything
    for (int i = 0; i < 4; i++) step(1, 20, 0, 20, 0, 0, 0, 0);
    step(1, 0, 1, 0, 1, 0, 0, 1);
    @(negedge CLK);
    chk("flush_occupancy", iq.occupancy, 0);
    chk("flush_issue_valid", iq.issue_valid, 0);
    step(0, 0, 0, 0, 0, 1, 20, 0);
    idle(2);

    // Randomized traffic with an asynchronous reset midway
    for (int n = 0; n < 3000; n++) begin
      step(1'($urandom_range(0, 3) != 0),
           TAG_W'($urandom_range(0, 7)), 1'($urandom_range(0, 2) == 0),
           TAG_W'($urandom_range(0, 7)), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 1)), TAG_W'($urandom_range(0, 7)),
           1'($urandom_range(0, 59) == 0));
      if (n == 1500) async_reset();
    end
    idle(1);
    @(negedge CLK);
    chk("scoreboard_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/issue_queue.md
# issue_queue

Out-of-order issue queue sitting directly upstream of the execute stage. Accepts renamed instructions from dispatch, holds them until both source physical registers are ready, and issues the oldest ready instruction, one per cycle, into the execute stage. Readiness is tracked by snooping the execute stage's result broadcast (`broadcast_flag` and `broadcast_map`).

## Interface
Parameters:
- DEPTH, 8, number of entries (power of two, ≥2)
- TAG_W, 6, physical register map width
- PAYLOAD_W, 128, opaque execute-stage payload width (instr, PC, ALU control, shamt, arch dest, mem flags, branch info)

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RESET  in  1  asynchronous, active-high reset
- flush  in  1  synchronous squash of all entries (mispredict)
- disp_valid  in  1  dispatch offers an instruction
- disp_ready  out  1  queue can accept; combinational: occupancy < DEPTH and !flush
- disp_instr_num  in  32  ROB sequence number; nonzero, monotonic, smaller = older
- disp_srcA_map / disp_srcB_map  in  TAG_W  source physical tags
- disp_srcA_rdy / disp_srcB_rdy  in  1  source already available at rename
- disp_RegWr_map  in  TAG_W  destination physical tag
- disp_RegWr_flag  in  1  instruction writes a register
- disp_payload  in  PAYLOAD_W  carried unchanged to issue
- broadcast_flag  in  1  execute stage result valid
- broadcast_map  in  TAG_W  physical tag being produced
- issue_valid  out  1  registered; issue fields valid this cycle
- issue_instr_num  out  32  registered; 0 when !issue_valid
- issue_RegWr_map  out  TAG_W  registered
- issue_RegWr_flag  out  1  registered; 0 when !issue_valid
- issue_payload  out  PAYLOAD_W  registered; 0 when !issue_valid
- occupancy  out  $clog2(DEPTH)+1  registered count of valid entries

## Operation
- Per entry: valid, instr_num, srcA/B map, srcA/B rdy, RegWr map/flag, payload.
- Dispatch fires when disp_valid && disp_ready. It writes the lowest-index invalid entry.
- Dispatch wakeup bypass: if broadcast_flag is high and broadcast_map equals a dispatching source tag, that source's rdy bit is stored as 1.
- Wakeup: on each edge with broadcast_flag high, every valid entry whose srcX_map == broadcast_map sets srcX_rdy. Both sources of one entry may wake on the same edge.
- Select (combinational, from registered state): an entry is eligible when valid && srcA_rdy && srcB_rdy. The winner is the eligible entry with the smallest instr_num. Ties cannot occur.
- Issue (at the edge): the winner's fields load into the issue_* registers, issue_valid becomes 1, and the winner's valid bit clears. With no eligible entry, issue_valid, issue_instr_num, issue_RegWr_flag and issue_payload load 0. The execute stage treats instr_num 0 as a bubble.
- The execute stage never stalls. Issue is unconditional, with no back-pressure.
- Occupancy next value = occupancy + dispatch_fire − issue_fire.
- Full: disp_ready = 0, so dispatch is not accepted even if an issue frees an entry on the same edge.
- Empty: no issue. A dispatch into an empty queue becomes eligible no earlier than the next cycle.
- Flush: at the edge, all valid bits clear, occupancy → 0 and the issue_* registers load bubble values. A dispatch offered in the flush cycle is dropped; disp_ready is already 0.
- Priority: RESET > flush > dispatch/wakeup/issue.
- Reset (asynchronous): all valid bits 0, occupancy 0, issue_valid 0, issue_instr_num 0, issue_RegWr_map 0, issue_RegWr_flag 0, issue_payload 0. disp_ready reads 1 after reset deasserts.
- Reset asserted mid-operation discards all entries immediately, regardless of CLK.

## Timing
- Dispatch with both sources ready, at edge k: eligible in cycle k→k+1. issue_valid is high after edge k+1, so dispatch-to-issue is 1 cycle minimum.
- Broadcast high in the cycle before edge k: rdy is set at edge k. The dependent instruction issues at edge k+1, giving back-to-back issue behind a 1-cycle producer.
- Maximum throughput is one issue per cycle. Dispatch and issue can occur on the same edge.
- disp_ready is combinational from occupancy and flush only. It has no path from disp_valid.

## Test plan
- Reset with RESET=1 mid-cycle, no clock edge → all issue_* outputs 0, occupancy 0, disp_ready 1 after release.
- Dispatch instr 5 (both rdy) at edge 1 → issue_valid=1, issue_instr_num=5 after edge 2; occupancy 1→0.
- Dispatch 7 (srcA=12 not rdy), then 8 (rdy) → 8 issues first. Broadcast map 12 → 7 issues on the following edge. Instruction order is 8, then 7.
- Fill 8 entries, all waiting on map 3 → disp_ready=0 and occupancy=8. Broadcast 3 → entries issue oldest-first, one per cycle, over 8 cycles. disp_ready returns to 1 after the first issue.
- Dispatch with srcB_map=9 while broadcast_flag=1, broadcast_map=9 → entry is stored ready and issues the next edge.
- 4 entries valid, assert flush together with disp_valid → next cycle occupancy 0, issue_valid 0, dropped dispatch never issues.
